// File: rtl/span_pkg.sv
// Shared types, offsets and helpers for the SPAN margin engine.
// Register layout is derived from the tier and month counts.
package span_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCUM,
    S_SCAN,
    S_SPREAD,
    S_DONE
  } state_t;

  localparam int N_SCEN = 5;

  function automatic int pos_base(input int n_tiers);
    return 4 + n_tiers;
  endfunction

  function automatic int mat_base(input int n_tiers,
                                  input int n_months);
    return pos_base(n_tiers) + n_months;
  endfunction

  function automatic int res_base(input int n_tiers,
                                  input int n_months);
    return mat_base(n_tiers, n_months) + n_months;
  endfunction

  // Clamp a non-negative value to w bits of unsigned range.
  function automatic logic [63:0] sat_u(input logic [63:0] v,
                                        input int w);
    logic [63:0] mx;
    mx = (64'd1 << w) - 64'd1;
    return (v > mx) ? mx : v;
  endfunction

endpackage

// File: rtl/span_margin_engine_if.sv
// Memory-mapped register bus of the SPAN margin engine.
// The host is the master; the engine is the slave.
interface span_margin_engine_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16
);
  logic              chipselect;
  logic              write;
  logic              read;
  logic [ADDR_W-1:0] offset;
  logic [DATA_W-1:0] writeData;
  logic [DATA_W-1:0] readData;
  logic              irq;

  modport master (
    output chipselect, write, read, offset, writeData,
    input  readData, irq
  );

  modport slave (
    input  chipselect, write, read, offset, writeData,
    output readData, irq
  );
endinterface

// File: rtl/span_tier_classify.sv
// Maps a maturity to the first tier whose threshold covers it;
// maturities beyond every threshold land in the last tier.
module span_tier_classify #(
  parameter int N_TIERS = 3,
  parameter int MAT_W   = 8,
  parameter int TW      = 2
) (
  input  logic [MAT_W-1:0]              mat,
  input  logic [N_TIERS-1:0][MAT_W-1:0] thr,
  output logic [TW-1:0]                 tier
);

  // Scan downwards so the smallest matching tier wins.
  always_comb begin
    tier = TW'(N_TIERS - 1);
    for (int t = N_TIERS - 1; t >= 0; t--) begin
      if (mat <= thr[t]) tier = TW'(t);
    end
  end

endmodule

// File: rtl/span_margin_engine.sv
// SPAN initial-margin engine: scanning risk over five price
// moves plus an intermonth tier spread charge.
module span_margin_engine
  import span_pkg::*;
#(
  parameter int N_MONTHS = 8,
  parameter int N_TIERS  = 3,
  parameter int DATA_W   = 16,
  parameter int MAT_W    = 8,
  parameter int ADDR_W   = 5
) (
  input logic               clk,
  input logic               reset,
  span_margin_engine_if.slave bus
);

  localparam int POS_B = pos_base(N_TIERS);
  localparam int MAT_B = mat_base(N_TIERS, N_MONTHS);
  localparam int RES_B = res_base(N_TIERS, N_MONTHS);
  localparam int IW = (N_MONTHS > 1) ? $clog2(N_MONTHS) : 1;
  localparam int TW = (N_TIERS > 1) ? $clog2(N_TIERS) : 1;
  localparam int AW = DATA_W + $clog2(N_MONTHS) + 1;
  localparam int MW = DATA_W + 2;
  localparam int PW = AW + MW;
  localparam logic [63:0] MAXV = (64'd1 << DATA_W) - 64'd1;

  logic [DATA_W-1:0]              psr, rate;
  logic [N_TIERS-1:0][MAT_W-1:0]  thr;
  logic signed [DATA_W-1:0]       pos [N_MONTHS];
  logic [MAT_W-1:0]               mat [N_MONTHS];

  state_t                  state;
  logic                    busy, done, ovf;
  logic [IW-1:0]           idx;
  logic [2:0]              sidx;
  logic signed [AW-1:0]    net;
  logic signed [AW-1:0]    tnet [N_TIERS];
  logic signed [PW-1:0]    scan_acc;
  logic [DATA_W-1:0]       scan_q, tsc_q, margin_q;

  int                      off;
  logic                    wr, rd, start, clr;
  logic [TW-1:0]           tier;
  logic signed [MW-1:0]    mv;
  logic signed [PW-1:0]    loss;
  logic signed [63:0]      lsum, ssum;
  logic [63:0]             mn, scan64, tsc_full, marg_full;
  logic [DATA_W-1:0]       scan_n, tsc_n, marg_n;
  logic                    ovf_n;
  logic [DATA_W-1:0]       rd_mux;

  assign off   = int'(bus.offset);
  assign wr    = bus.chipselect & bus.write;
  assign rd    = bus.chipselect & bus.read;
  assign start = wr && off == 0 && bus.writeData[0] && !busy;
  assign clr   = wr && off == 0 && bus.writeData[1];
  assign bus.irq = done;

  span_tier_classify #(
    .N_TIERS(N_TIERS),
    .MAT_W  (MAT_W),
    .TW     (TW)
  ) u_tier (
    .mat (mat[idx]),
    .thr (thr),
    .tier(tier)
  );

  // Price move for the current scenario and the loss it implies.
  always_comb begin
    mv = '0;
    case (sidx)
      3'd1: mv = signed'({2'b00, psr});
      3'd2: mv = -signed'({2'b00, psr});
      3'd3: mv = signed'({3'b000, psr[DATA_W-1:1]});
      3'd4: mv = -signed'({3'b000, psr[DATA_W-1:1]});
      default: mv = '0;
    endcase
    loss = -(PW'(net) * PW'(mv));
  end

  // Spread charge, saturated results and overflow detection.
  always_comb begin
    lsum = '0;
    ssum = '0;
    for (int t = 0; t < N_TIERS; t++) begin
      if (tnet[t] > 0) lsum = lsum + 64'(tnet[t]);
      else             ssum = ssum - 64'(tnet[t]);
    end
    mn        = (lsum < ssum) ? lsum : ssum;
    tsc_full  = mn * 64'(rate);
    scan64    = 64'(scan_acc);
    scan_n    = DATA_W'(sat_u(scan64, DATA_W));
    tsc_n     = DATA_W'(sat_u(tsc_full, DATA_W));
    marg_full = 64'(scan_n) + 64'(tsc_n);
    marg_n    = DATA_W'(sat_u(marg_full, DATA_W));
    ovf_n     = (scan64 > MAXV) || (tsc_full > MAXV) ||
                (marg_full > MAXV);
  end

  // Configuration registers, frozen while a run is active.
  always_ff @(posedge clk) begin
    if (reset) begin
      psr  <= '0;
      rate <= '0;
      thr  <= '0;
      for (int i = 0; i < N_MONTHS; i++) begin
        pos[i] <= '0;
        mat[i] <= '0;
      end
    end else if (wr && !busy) begin
      if (off == 2) psr  <= bus.writeData;
      if (off == 3) rate <= bus.writeData;
      for (int t = 0; t < N_TIERS; t++) begin
        if (off == 4 + t) thr[t] <= bus.writeData[MAT_W-1:0];
      end
      for (int i = 0; i < N_MONTHS; i++) begin
        if (off == POS_B + i) pos[i] <= signed'(bus.writeData);
        if (off == MAT_B + i) mat[i] <= bus.writeData[MAT_W-1:0];
      end
    end
  end

  // Run sequencer: accumulate, scan, spread, then hold results.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      ovf      <= 1'b0;
      idx      <= '0;
      sidx     <= '0;
      net      <= '0;
      scan_acc <= '0;
      scan_q   <= '0;
      tsc_q    <= '0;
      margin_q <= '0;
      for (int t = 0; t < N_TIERS; t++) tnet[t] <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state    <= S_ACCUM;
            busy     <= 1'b1;
            done     <= 1'b0;
            ovf      <= 1'b0;
            idx      <= '0;
            sidx     <= '0;
            net      <= '0;
            scan_acc <= '0;
            for (int t = 0; t < N_TIERS; t++) tnet[t] <= '0;
          end else if (clr && state == S_DONE) begin
            state <= S_IDLE;
            done  <= 1'b0;
          end
        end
        S_ACCUM: begin
          net        <= net + AW'(pos[idx]);
          tnet[tier] <= tnet[tier] + AW'(pos[idx]);
          idx        <= idx + 1'b1;
          if (idx == IW'(N_MONTHS - 1)) state <= S_SCAN;
        end
        S_SCAN: begin
          if (loss > scan_acc) scan_acc <= loss;
          sidx <= sidx + 3'd1;
          if (sidx == 3'(N_SCEN - 1)) state <= S_SPREAD;
        end
        S_SPREAD: begin
          scan_q   <= scan_n;
          tsc_q    <= tsc_n;
          margin_q <= marg_n;
          if (ovf_n) ovf <= 1'b1;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Read-side decode; unmapped offsets read as zero.
  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      (off == 1):         rd_mux = DATA_W'({ovf, done, busy});
      (off == 2):         rd_mux = psr;
      (off == 3):         rd_mux = rate;
      (off == RES_B):     rd_mux = margin_q;
      (off == RES_B + 1): rd_mux = scan_q;
      (off == RES_B + 2): rd_mux = tsc_q;
      default:            rd_mux = '0;
    endcase
    for (int t = 0; t < N_TIERS; t++) begin
      if (off == 4 + t) rd_mux = DATA_W'(thr[t]);
    end
    for (int i = 0; i < N_MONTHS; i++) begin
      if (off == POS_B + i) rd_mux = pos[i];
      if (off == MAT_B + i) rd_mux = DATA_W'(mat[i]);
    end
  end

  // Registered read data, held between reads.
  always_ff @(posedge clk) begin
    if (reset)   bus.readData <= '0;
    else if (rd) bus.readData <= rd_mux;
  end

endmodule
